// File: rtl/cb_subtractor_seq_if.sv
// Purpose : valid/ready operand and result bundle for cb_subtractor_seq.
// Signals : in_valid/in_ready/a/b       operand handshake (master -> slave)
//           out_valid/out_ready/diff    result handshake (slave -> master)
//           borrow/overflow/bypass_cnt  result flags
// Modports: master = producer/consumer side, slave = the subtractor.
interface cb_subtractor_seq_if #(
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(WIDTH / 4 + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic [CW-1:0]    bypass_cnt;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow, bypass_cnt
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, overflow, bypass_cnt
    );
endinterface

// File: rtl/cb_subtractor_seq.sv
// Purpose : block-serial two's-complement subtractor, diff = a + ~b + 1,
//           one 4-bit carry-bypass block per clock, valid/ready on both sides.
// Ports   : clk  rising-edge clock
//           rst  asynchronous active-high reset
//           bus  cb_subtractor_seq_if.slave (operands in, result + flags out)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for operands, in_ready=1
// RUN     | processing block idx, one 4-bit block per cycle
// DONE    | result valid, held until out_ready
module cb_subtractor_seq #(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    cb_subtractor_seq_if.slave  bus
);
    localparam int NBLK = WIDTH / 4;
    localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int CW   = $clog2(NBLK + 1);
    localparam int MSB  = WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bn_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             overflow_q;
    logic [CW-1:0]    bypass_cnt_q;
    logic             out_valid_q;

    logic [IDXW+1:0]  base;
    logic [3:0]       blk_a;
    logic [3:0]       blk_bn;
    logic [4:0]       sum_d;
    logic             bypass_d;
    logic             carry_d;
    logic             last_blk;
    logic             overflow_d;

    assign base     = {idx_q, 2'b00};
    assign blk_a    = a_q[base +: 4];
    assign blk_bn   = bn_q[base +: 4];
    assign sum_d    = {1'b0, blk_a} + {1'b0, blk_bn} + {4'b0000, carry_q};
    // All four propagate bits set: the incoming carry passes straight through.
    // The sum bits still come from the ripple result, so the outcome matches.
    assign bypass_d = &(blk_a ^ blk_bn);
    assign carry_d  = bypass_d ? carry_q : sum_d[4];
    assign last_blk = (idx_q == IDXW'(NBLK - 1));
    // b's sign is the inverse of the latched ~b MSB; the result MSB is the
    // top bit of the final block's sum.
    assign overflow_d = (a_q[MSB] != ~bn_q[MSB]) && (sum_d[3] != a_q[MSB]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            bn_q         <= '0;
            carry_q      <= 1'b1;
            idx_q        <= '0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            overflow_q   <= 1'b0;
            bypass_cnt_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q          <= bus.a;
                        bn_q         <= ~bus.b;
                        carry_q      <= 1'b1;
                        idx_q        <= '0;
                        bypass_cnt_q <= '0;
                        diff_q       <= '0;
                        state_q      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    diff_q[base +: 4] <= sum_d[3:0];
                    carry_q           <= carry_d;
                    if (bypass_d) begin
                        bypass_cnt_q <= bypass_cnt_q + CW'(1);
                    end
                    if (last_blk) begin
                        idx_q       <= '0;
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        borrow_q    <= ~carry_d;
                        overflow_q  <= overflow_d;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Held low while reset is asserted so nothing is accepted during reset.
    assign bus.in_ready   = (state_q == ST_IDLE) && !rst;
    assign bus.out_valid  = out_valid_q;
    assign bus.diff       = diff_q;
    assign bus.borrow     = borrow_q;
    assign bus.overflow   = overflow_q;
    assign bus.bypass_cnt = bypass_cnt_q;
endmodule
